// File: rtl/ntt.sv
// ntt: iterative 256-point forward/inverse NTT engine with one butterfly unit (ML-DSA ring).
// Define NTT_KYBER_EN to add the ML-KEM ring, selected by i_algo.
module ntt (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ready,
    input  logic               i_algo,
    input  logic               i_intt,
    input  logic signed [31:0] i_data,
    output logic               o_valid,
    output logic signed [31:0] o_data
);
    localparam logic [22:0] Q_DSA    = 23'd8380417;
    localparam logic [22:0] Z_DSA    = 23'd1753;
    localparam logic [22:0] NINV_DSA = 23'd8347681;
`ifdef NTT_KYBER_EN
    localparam logic [22:0] Q_KEM    = 23'd3329;
    localparam logic [22:0] Z_KEM    = 23'd17;
    localparam logic [22:0] NINV_KEM = 23'd3303;
`endif

    typedef enum logic [1:0] {S_LOAD, S_COMP, S_OUT} state_t;
    state_t r_state, w_next;

    logic [22:0] r_w   [256];
    logic [22:0] r_pow [256];
    logic [22:0] r_pw;
    logic [8:0]  r_cnt;
    logic [2:0]  r_layer;
    logic        r_scale, r_algo, r_intt;

    logic        w_algo;
    logic [22:0] w_q, w_zeta, w_ninv;
    logic [2:0]  w_lg, w_last_layer;
    logic [6:0]  w_g, w_mask;
    logic [7:0]  w_lo, w_hi, w_G, w_k, w_tidx;
    logic [22:0] w_a, w_b, w_tw, w_ma, w_mb, w_prod, w_lo_new, w_hi_new;
    logic [45:0] w_p;
    logic        w_bf_last, w_comp_done;

    function automatic logic [22:0] add_mod(input logic [22:0] a, input logic [22:0] b, input logic [22:0] q);
        logic [23:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return 23'(s);
    endfunction

    function automatic logic [22:0] sub_mod(input logic [22:0] a, input logic [22:0] b, input logic [22:0] q);
        logic [23:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + {1'b0, q};
        return 23'(s);
    endfunction

    function automatic logic [7:0] brv8(input logic [7:0] k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = k[7 - i];
        return r;
    endfunction

`ifdef NTT_KYBER_EN
    function automatic logic [6:0] brv7(input logic [6:0] k);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[i] = k[6 - i];
        return r;
    endfunction

    // Canonical residue of a signed 32-bit input (% keeps the dividend's sign).
    function automatic logic [22:0] red_in(input logic signed [31:0] d, input logic algo);
        logic signed [32:0] s, r;
        s = 33'(d);
        if (algo) begin
            r = s % 33'sd8380417;
            if (r < 0) r = r + 33'sd8380417;
        end else begin
            r = s % 33'sd3329;
            if (r < 0) r = r + 33'sd3329;
        end
        return 23'(r);
    endfunction

    function automatic logic [22:0] red_prod(input logic [45:0] p, input logic algo);
        logic [45:0] r;
        r = algo ? p % 46'd8380417 : p % 46'd3329;
        return 23'(r);
    endfunction

    // Ring choice for index 0 comes straight from the port; later edges use the latched copy.
    assign w_algo = (r_state == S_LOAD && r_cnt == 9'd0) ? i_algo : r_algo;
    assign w_q    = w_algo ? Q_DSA : Q_KEM;
    assign w_zeta = w_algo ? Z_DSA : Z_KEM;
    assign w_ninv = w_algo ? NINV_DSA : NINV_KEM;
    assign w_tidx = w_algo ? brv8(w_k) : {1'b0, brv7(w_k[6:0])};
`else
    function automatic logic [22:0] red_in(input logic signed [31:0] d, input logic unused_algo);
        logic signed [32:0] s, r;
        s = 33'(d);
        r = s % 33'sd8380417;
        if (r < 0) r = r + 33'sd8380417;
        return 23'(r);
    endfunction

    function automatic logic [22:0] red_prod(input logic [45:0] p, input logic unused_algo);
        logic [45:0] r;
        r = p % 46'd8380417;
        return 23'(r);
    endfunction

    logic w_unused_algo;
    assign w_unused_algo = i_algo ^ r_algo;
    assign w_algo = 1'b1;
    assign w_q    = Q_DSA;
    assign w_zeta = Z_DSA;
    assign w_ninv = NINV_DSA;
    assign w_tidx = brv8(w_k);
`endif

    // Butterfly addressing: span 2^lg, group g, twiddle index k (ascending fwd, descending inv).
    always_comb begin
        w_lg = 3'd7 - r_layer;
        if (r_intt) w_lg = w_algo ? r_layer : r_layer + 3'd1;
    end
    assign w_g          = r_cnt[6:0] >> w_lg;
    assign w_mask       = (7'd1 << w_lg) - 7'd1;
    assign w_lo         = (8'(w_g) << ({1'b0, w_lg} + 4'd1)) | 8'(r_cnt[6:0] & w_mask);
    assign w_hi         = w_lo | (8'd1 << w_lg);
    assign w_G          = 8'd128 >> w_lg;
    assign w_k          = r_intt ? ((w_G << 1) - 8'd1 - 8'(w_g)) : (w_G + 8'(w_g));
    assign w_tw         = r_pow[w_tidx];
    assign w_a          = r_w[w_lo];
    assign w_b          = r_w[w_hi];
    assign w_last_layer = w_algo ? 3'd7 : 3'd6;
    assign w_bf_last    = (r_cnt[6:0] == 7'd127) && (r_layer == w_last_layer);
    assign w_comp_done  = r_scale ? (r_cnt == 9'd255) : (w_bf_last && !r_intt);

    // Single modular multiplier shared by twiddle-table build, butterflies and scaling.
    always_comb begin
        w_ma = r_pw;
        w_mb = w_zeta;
        if (r_state == S_COMP) begin
            if (r_scale) begin
                w_ma = r_w[r_cnt[7:0]];
                w_mb = w_ninv;
            end else begin
                w_ma = w_tw;
                w_mb = r_intt ? sub_mod(w_b, w_a, w_q) : w_b;
            end
        end
    end
    assign w_p      = 46'(w_ma) * 46'(w_mb);
    assign w_prod   = red_prod(w_p, w_algo);
    assign w_lo_new = r_intt ? add_mod(w_a, w_b, w_q) : add_mod(w_a, w_prod, w_q);
    assign w_hi_new = r_intt ? w_prod : sub_mod(w_a, w_prod, w_q);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (i_ready && r_cnt == 9'd255) w_next = S_COMP;
            S_COMP:  if (w_comp_done) w_next = S_OUT;
            S_OUT:   if (r_cnt == 9'd256) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_LOAD;
            r_cnt   <= 9'd0;
            r_layer <= 3'd0;
            r_scale <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= 32'sd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_LOAD: if (i_ready) begin
                    if (r_cnt == 9'd0) begin
                        r_algo <= i_algo;
                        r_intt <= i_intt;
                    end
                    r_cnt   <= (r_cnt == 9'd255) ? 9'd0 : r_cnt + 9'd1;
                    r_layer <= 3'd0;
                    r_scale <= 1'b0;
                end
                S_COMP: begin
                    if (w_comp_done) begin
                        r_cnt   <= 9'd1;
                        o_valid <= 1'b1;
                        o_data  <= {9'd0, r_w[0]};
                    end else if (r_scale) begin
                        r_cnt <= r_cnt + 9'd1;
                    end else if (r_cnt[6:0] == 7'd127) begin
                        r_cnt   <= 9'd0;
                        r_layer <= r_layer + 3'd1;
                        if (w_bf_last) r_scale <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                S_OUT: begin
                    if (r_cnt == 9'd256) begin
                        r_cnt   <= 9'd0;
                        o_valid <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 9'd1;
                        o_data <= {9'd0, r_w[r_cnt[7:0]]};
                    end
                end
                default: r_cnt <= 9'd0;
            endcase
        end
    end

    // Coefficient store and twiddle powers ζ^n, the latter built one entry per load edge.
    always_ff @(posedge i_clk) begin
        if (r_state == S_LOAD && i_ready) begin
            r_w[r_cnt[7:0]] <= red_in(i_data, w_algo);
            if (r_cnt == 9'd0) begin
                r_pow[0] <= 23'd1;
                r_pw     <= 23'd1;
            end else begin
                r_pow[r_cnt[7:0]] <= w_prod;
                r_pw              <= w_prod;
            end
        end else if (r_state == S_COMP) begin
            if (r_scale) begin
                r_w[r_cnt[7:0]] <= w_prod;
            end else begin
                r_w[w_lo] <= w_lo_new;
                r_w[w_hi] <= w_hi_new;
            end
        end
    end
endmodule

// File: tb/tb_ntt.sv
// tb_ntt: randomized self-checking bench for ntt against a direct FIPS 203/204 loop model.
`timescale 1ns/1ps
module tb_ntt;
    logic               clk  = 1'b0;
    logic               rst  = 1'b1;
    logic               rdy  = 1'b0;
    logic               algo = 1'b1;
    logic               intt = 1'b0;
    logic signed [31:0] din  = 32'sd0;
    logic signed [31:0] dout;
    logic               vld;

    int     n_chk = 0;
    int     n_err = 0;
    int     vin  [256];
    longint expv [256];
    longint got  [256];

    ntt dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ready(rdy),
        .i_algo (algo),
        .i_intt (intt),
        .i_data (din),
        .o_valid(vld),
        .o_data (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got_v, input longint exp_v);
        n_chk++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    function automatic longint powmod(input longint b, input int e, input longint q);
        longint r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % q;
        return r;
    endfunction

    function automatic int brv(input int k, input int nb);
        int r = 0;
        for (int i = 0; i < nb; i++) if (k[i]) r |= (1 << (nb - 1 - i));
        return r;
    endfunction

    // Reference: textbook loops of FIPS 204 Alg. 41/42 and FIPS 203 Alg. 9/10.
    task automatic ref_model(input int dsa, input int inv);
        longint q, zr, t, zz, sc;
        longint w  [256];
        longint zt [256];
        int nb, m;
        q  = dsa ? 64'd8380417 : 64'd3329;
        zr = dsa ? 64'd1753 : 64'd17;
        sc = dsa ? 64'd8347681 : 64'd3303;
        nb = dsa ? 8 : 7;
        for (int k = 0; k < (1 << nb); k++) zt[k] = powmod(zr, brv(k, nb), q);
        for (int i = 0; i < 256; i++) w[i] = ((longint'(vin[i]) % q) + q) % q;
        if (!inv) begin
            m = 0;
            for (int len = 128; len >= (dsa ? 1 : 2); len /= 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    m++;
                    zz = zt[m];
                    for (int j = st; j < st + len; j++) begin
                        t = (zz * w[j + len]) % q;
                        w[j + len] = (w[j] - t + q) % q;
                        w[j] = (w[j] + t) % q;
                    end
                end
        end else begin
            m = dsa ? 256 : 128;
            for (int len = (dsa ? 1 : 2); len < 256; len *= 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    m--;
                    zz = dsa ? (q - zt[m]) : zt[m];
                    for (int j = st; j < st + len; j++) begin
                        t = w[j];
                        w[j] = (t + w[j + len]) % q;
                        if (dsa) w[j + len] = (zz * ((t - w[j + len] + q) % q)) % q;
                        else     w[j + len] = (zz * ((w[j + len] - t + q) % q)) % q;
                    end
                end
            for (int j = 0; j < 256; j++) w[j] = (w[j] * sc) % q;
        end
        for (int i = 0; i < 256; i++) expv[i] = w[i];
    endtask

    task automatic load_vec(input logic a, input logic inv, input int gaps, input int noise);
        int g;
        for (int i = 0; i < 256; i++) begin
            if (gaps != 0) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk);
                    rdy = 1'b0;
                    din = $urandom;
                end
            end
            @(negedge clk);
            rdy = 1'b1;
            din = vin[i];
            if (i == 0 || noise == 0) begin
                algo = a;
                intt = inv;
            end else begin
                algo = 1'($urandom);
                intt = 1'($urandom);
            end
        end
    endtask

    task automatic run_xform(input logic a, input logic inv, input int gaps, input int noise,
                             input int exp_lat, input string tag);
        int lat, vrun;
        for (int i = 0; i < 256; i++) got[i] = -1;
        load_vec(a, inv, gaps, noise);
        @(negedge clk);
        rdy = 1'b0;
        lat = 0;
        while (!vld && lat < 3000) begin
            if (noise != 0) begin
                rdy  = 1'($urandom);
                din  = $urandom;
                algo = 1'($urandom);
                intt = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        rdy = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        if (!vld) return;
        vrun = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            got[i] = longint'(dout);
            if (vld) vrun++;
        end
        chk({tag, "_valid_run"}, vrun, 256);
        @(negedge clk);
        chk({tag, "_valid_drop"}, vld, 0);
    endtask

    task automatic cmp_all(input string tag);
        for (int i = 0; i < 256; i++) chk($sformatf("%s[%0d]", tag, i), got[i], expv[i]);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("reset_valid", vld, 0);
        chk("reset_data", longint'(dout), 0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) vin[i] = (i == 0) ? 1 : 0;
        run_xform(1'b1, 1'b0, 0, 0, 1024, "dsa_fwd_delta");
        for (int i = 0; i < 256; i++) expv[i] = 1;
        cmp_all("dsa_fwd_delta");

        for (int i = 0; i < 256; i++) vin[i] = 1;
        run_xform(1'b1, 1'b1, 0, 0, 1280, "dsa_inv_ones");
        for (int i = 0; i < 256; i++) expv[i] = (i == 0) ? 1 : 0;
        cmp_all("dsa_inv_ones");

        for (int i = 0; i < 256; i++) vin[i] = i;
        ref_model(1, 1);
        run_xform(1'b1, 1'b1, 0, 0, 1280, "dsa_inv_ramp");
        cmp_all("dsa_inv_ramp");
        for (int i = 0; i < 256; i++) vin[i] = int'(got[i]);
        run_xform(1'b1, 1'b0, 1, 0, 1024, "dsa_roundtrip");
        for (int i = 0; i < 256; i++) expv[i] = i;
        cmp_all("dsa_roundtrip");

        for (int i = 0; i < 256; i++) vin[i] = (i == 0) ? -1 : 0;
        run_xform(1'b1, 1'b0, 0, 0, 1024, "dsa_fwd_neg");
        for (int i = 0; i < 256; i++) expv[i] = 8380416;
        cmp_all("dsa_fwd_neg");

        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        ref_model(1, 0);
        run_xform(1'b1, 1'b0, 1, 1, 1024, "dsa_fwd_rand");
        cmp_all("dsa_fwd_rand");

        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        ref_model(1, 1);
        run_xform(1'b1, 1'b1, 1, 1, 1280, "dsa_inv_rand");
        cmp_all("dsa_inv_rand");

        // Abort a transform mid-compute; nothing of it may appear on the outputs.
        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        load_vec(1'b1, 1'b0, 0, 0);
        @(negedge clk);
        rdy  = 1'b0;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (vld) seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", vld, 0);
        chk("rst_mid_quiet", seen, 0);
        for (int i = 0; i < 256; i++) vin[i] = (i == 0) ? 1 : 0;
        run_xform(1'b1, 1'b0, 0, 0, 1024, "after_rst");
        for (int i = 0; i < 256; i++) expv[i] = 1;
        cmp_all("after_rst");

`ifdef NTT_KYBER_EN
        for (int i = 0; i < 256; i++) vin[i] = (i == 0) ? 1 : 0;
        run_xform(1'b0, 1'b0, 0, 0, 896, "kem_fwd_delta");
        for (int i = 0; i < 256; i++) expv[i] = (i % 2 == 0) ? 1 : 0;
        cmp_all("kem_fwd_delta");

        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        ref_model(0, 0);
        run_xform(1'b0, 1'b0, 1, 1, 896, "kem_fwd_rand");
        cmp_all("kem_fwd_rand");

        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        ref_model(0, 1);
        run_xform(1'b0, 1'b1, 1, 1, 1152, "kem_inv_rand");
        cmp_all("kem_inv_rand");
`else
        for (int i = 0; i < 256; i++) vin[i] = $urandom;
        ref_model(1, 0);
        run_xform(1'b0, 1'b0, 0, 0, 1024, "algo_ignored");
        cmp_all("algo_ignored");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ntt.md
# ntt

Iterative 256-point number-theoretic transform engine for the lattice-crypto datapath. It streams in one polynomial, computes a forward or inverse NTT in place with a single butterfly unit, and streams the result out. It supports the ML-DSA (Dilithium) ring and, optionally, the ML-KEM (Kyber) ring.

## Interface
- No parameters. ML-DSA: q = 8380417, ζ = 1753. ML-KEM: q = 3329, ζ = 17.
- i_clk  in  1  clock. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous active-high reset.
- i_ready  in  1  input-data strobe; one coefficient is accepted per cycle while high.
- i_algo  in  1  1 = ML-DSA, 0 = ML-KEM.
- i_intt  in  1  1 = inverse NTT, 0 = forward NTT.
- i_data  in  32 signed  input coefficient.
- o_valid  out  1  output coefficient valid.
- o_data  out  32 signed  output coefficient, canonical in [0, q-1].

## Operation
- States: LOAD → COMPUTE → OUTPUT → LOAD.
- Storage: 256-entry coefficient array with 23-bit entries.
- **LOAD**
  - Each rising edge with i_ready=1 stores i_data mod q, reduced to [0, q-1], at index cnt; cnt then increments.
  - Negative inputs wrap: -1 is stored as q-1.
  - i_algo and i_intt are latched on the edge that stores index 0.
  - If i_ready drops mid-load, loading pauses and cnt holds. It resumes when i_ready returns.
  - When index 255 is stored, the block enters COMPUTE.
- **COMPUTE**
  - One butterfly per cycle.
  - ML-DSA forward: FIPS 204 Alg. 41, 8 layers. Inverse: Alg. 42, including the final multiply by 256⁻¹ = 8347681.
  - ML-KEM forward: FIPS 203 Alg. 9, 7 layers over 128 pairs. Inverse: Alg. 10, including the multiply by 128⁻¹ = 3303.
  - Twiddles come from ROM: ζ^brv(k) mod q. brv is 8-bit for ML-DSA and 7-bit for ML-KEM.
  - All arithmetic is exact modular arithmetic. Every stored value stays in [0, q-1]. Results carry no Montgomery factor.
- **OUTPUT**
  - Emits coefficients 0..255 in index order, one per cycle, with o_valid=1 on each.
  - Returns to LOAD when done.
- i_ready is ignored in COMPUTE and OUTPUT.
- Reset value of every output: o_valid=0, o_data=0.
- Reset in any state: the block returns to LOAD with cnt=0, and any transform in progress is discarded.

## Timing
- The last load edge moves the block into COMPUTE.
- COMPUTE duration:
  - ML-DSA: 1024 cycles (8×128).
  - ML-KEM: 896 cycles (7×128).
  - Inverse transforms add a 256-cycle scaling pass.
- o_valid rises on the cycle after COMPUTE ends.
- o_valid stays high for exactly 256 consecutive cycles.
- o_data is registered and stable for the full cycle in which o_valid=1. It is safe to sample at the negedge.
- A new LOAD may begin on the cycle after the last output.

## Configuration
- Macro NTT_KYBER_EN.
  - Defined: i_algo selects the ring. The ML-KEM ROM, the 7-layer schedule and the 3303 scaling are compiled in.
  - Undefined: i_algo is ignored and treated as 1; only ML-DSA logic is built.

## Test plan
- ML-DSA forward, input [1, 0, …, 0] → all 256 outputs = 1; the first o_valid arrives 1024 cycles after COMPUTE entry.
- ML-DSA inverse, input all 1 → output [1, 0, …, 0]; o_valid arrives 1280 cycles after COMPUTE entry.
- ML-DSA inverse of ramp i (i=0..255) → must match the software Alg. 42 model. A forward pass on that result must return 0..255 exactly.
- ML-KEM forward (NTT_KYBER_EN defined), input [1, 0, …, 0] → even indices = 1, odd indices = 0.
- Input -1 at index 0, zeros elsewhere, ML-DSA forward → all outputs = 8380416.
- Assert i_rst mid-COMPUTE, then reload [1, 0, …, 0] forward → o_valid stays 0 until the new transform completes; outputs are all 1.
